// File: rtl/wb_uart_tx_arbiter.sv
// wb_uart_tx_arbiter
// Two-master Wishbone arbiter in front of a single UART TX write port.
// The owning master is passed straight through to the UART. Once an owner
// has had MAX_BURST strobes accepted while the other master is requesting,
// the owner is stalled, its outstanding acks are drained, and ownership
// moves to the other master. Simultaneous requests from idle are settled
// round-robin.
//
// State table
//   state  | meaning
//   IDLE   | no owner; UART cycle low, both masters stalled
//   OWN0   | master 0 passed through to the UART
//   OWN1   | master 1 passed through to the UART
//   DRAIN0 | master 0 burst exhausted; waiting for its outstanding acks
//   DRAIN1 | master 1 burst exhausted; waiting for its outstanding acks
//
// Ports
//   i_clk, i_reset_n               clock, synchronous active-low reset
//   i_m0_cyc/stb/data, o_m0_ack/stall   master 0 Wishbone slave side
//   i_m1_cyc/stb/data, o_m1_ack/stall   master 1 Wishbone slave side
//   o_s_cyc/stb/data, i_s_ack/stall     Wishbone master side to UART TX
//   o_grant                        one-hot owner: bit0 = m0, bit1 = m1

module wb_uart_tx_arbiter #(
   parameter int DW        = 8,
   parameter int MAX_BURST = 16
) (
   input  logic          i_clk,
   input  logic          i_reset_n,
   input  logic          i_m0_cyc,
   input  logic          i_m0_stb,
   input  logic [DW-1:0] i_m0_data,
   output logic          o_m0_ack,
   output logic          o_m0_stall,
   input  logic          i_m1_cyc,
   input  logic          i_m1_stb,
   input  logic [DW-1:0] i_m1_data,
   output logic          o_m1_ack,
   output logic          o_m1_stall,
   output logic          o_s_cyc,
   output logic          o_s_stb,
   output logic [DW-1:0] o_s_data,
   input  logic          i_s_ack,
   input  logic          i_s_stall,
   output logic [1:0]    o_grant
);

   localparam int BW = $clog2(MAX_BURST) + 1;
   localparam logic [BW-1:0] BURST_MAX = BW'(MAX_BURST);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      OWN0   = 3'd1,
      OWN1   = 3'd2,
      DRAIN0 = 3'd3,
      DRAIN1 = 3'd4
   } state_t;

   state_t        state;
   logic          last;
   logic [BW-1:0] burst;
   logic [BW-1:0] outst;

   logic          accept;
   logic          ack_ok;
   logic          owner_cyc;
   logic          other_cyc;
   logic [BW-1:0] burst_nxt;
   logic [BW-1:0] outst_nxt;

   // Acks are only honoured while something is outstanding, so a stray or
   // abandoned ack can neither underflow the counter nor reach a master.
   assign accept = o_s_stb && !i_s_stall;
   assign ack_ok = i_s_ack && (outst != '0);

   always_comb begin
      owner_cyc = 1'b0;
      other_cyc = 1'b0;
      if (state == OWN0 || state == DRAIN0) begin
         owner_cyc = i_m0_cyc;
         other_cyc = i_m1_cyc;
      end else if (state == OWN1 || state == DRAIN1) begin
         owner_cyc = i_m1_cyc;
         other_cyc = i_m0_cyc;
      end
   end

   always_comb begin
      burst_nxt = burst;
      if (accept && burst != BURST_MAX)
         burst_nxt = burst + BW'(1);
   end

   always_comb begin
      outst_nxt = outst;
      case ({accept, ack_ok})
         2'b10:   outst_nxt = outst + BW'(1);
         2'b01:   outst_nxt = outst - BW'(1);
         default: outst_nxt = outst;
      endcase
   end

   // Output decode from the registered state: grant and ownership can only
   // change at a clock edge, while data/strobe of the owner pass straight
   // through so the UART sees no added latency.
   always_comb begin
      o_s_cyc    = 1'b0;
      o_s_stb    = 1'b0;
      o_s_data   = '0;
      o_m0_ack   = 1'b0;
      o_m0_stall = 1'b1;
      o_m1_ack   = 1'b0;
      o_m1_stall = 1'b1;
      o_grant    = 2'b00;
      case (state)
         OWN0: begin
            o_s_cyc    = i_m0_cyc;
            o_s_stb    = i_m0_stb;
            o_s_data   = i_m0_data;
            o_m0_stall = i_s_stall;
            o_m0_ack   = ack_ok;
            o_grant    = 2'b01;
         end
         OWN1: begin
            o_s_cyc    = i_m1_cyc;
            o_s_stb    = i_m1_stb;
            o_s_data   = i_m1_data;
            o_m1_stall = i_s_stall;
            o_m1_ack   = ack_ok;
            o_grant    = 2'b10;
         end
         DRAIN0: begin
            o_s_cyc  = 1'b1;
            o_m0_ack = ack_ok;
            o_grant  = 2'b01;
         end
         DRAIN1: begin
            o_s_cyc  = 1'b1;
            o_m1_ack = ack_ok;
            o_grant  = 2'b10;
         end
         default: ;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         state <= IDLE;
         last  <= 1'b1;
         burst <= '0;
         outst <= '0;
      end else begin
         case (state)
            IDLE: begin
               // last == 1 means m1 was served most recently, so m0 wins a tie
               if (i_m0_cyc && (!i_m1_cyc || last)) begin
                  state <= OWN0;
                  last  <= 1'b0;
                  burst <= '0;
                  outst <= '0;
               end else if (i_m1_cyc) begin
                  state <= OWN1;
                  last  <= 1'b1;
                  burst <= '0;
                  outst <= '0;
               end
            end
            OWN0, OWN1: begin
               if (!owner_cyc) begin
                  state <= IDLE;
                  burst <= '0;
                  outst <= '0;
               end else begin
                  burst <= burst_nxt;
                  outst <= outst_nxt;
                  // Using the post-accept count stops the owner right on its
                  // MAX_BURST-th accepted strobe instead of one later.
                  if (burst_nxt == BURST_MAX && other_cyc)
                     state <= (state == OWN0) ? DRAIN0 : DRAIN1;
               end
            end
            DRAIN0, DRAIN1: begin
               if (outst_nxt == '0) begin
                  state <= (state == DRAIN0) ? OWN1 : OWN0;
                  last  <= (state == DRAIN0);
                  burst <= '0;
                  outst <= '0;
               end else begin
                  outst <= outst_nxt;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/wb_uart_tx_arbiter.md
WB_UART_TX_ARBITER -- requirements
Module: wb_uart_tx_arbiter

Interface
REQ-001 SHALL have parameter DW, default 8, byte width of write data.
REQ-002 SHALL have parameter MAX_BURST, default 16, maximum strobes accepted per grant while the other master waits.
REQ-003 SHALL have port i_clk  in  1  clock.
REQ-004 SHALL have port i_reset_n  in  1  reset, synchronous, active-low.
REQ-005 SHALL have ports i_m0_cyc, i_m0_stb  in  1 each  master 0 Wishbone cycle and strobe.
REQ-006 SHALL have port i_m0_data  in  DW  master 0 byte.
REQ-007 SHALL have ports o_m0_ack, o_m0_stall  out  1 each  master 0 acknowledge and stall.
REQ-008 SHALL have ports i_m1_cyc, i_m1_stb, i_m1_data, o_m1_ack, o_m1_stall, identical to master 0 ports, for master 1.
REQ-009 SHALL have ports o_s_cyc, o_s_stb  out  1 each  cycle and strobe to the UART TX Wishbone port.
REQ-010 SHALL have port o_s_data  out  DW  byte to the UART TX port.
REQ-011 SHALL have ports i_s_ack, i_s_stall  in  1 each  UART TX acknowledge and stall.
REQ-012 SHALL have port o_grant  out  2  one-hot owner status: bit0 = m0, bit1 = m1, 00 = idle.

Function
REQ-013 SHALL implement FSM states IDLE, OWN0, OWN1, DRAIN0, DRAIN1.
REQ-014 IDLE: o_s_cyc=0, o_s_stb=0, both masters stall=1, ack=0.
REQ-015 IDLE with exactly one i_mX_cyc=1 SHALL go to OWNX next cycle.
REQ-016 IDLE with both cyc=1 SHALL grant the master not in register last (round-robin); reset value of last=1, so m0 wins first.
REQ-017 Entering OWNX SHALL set last=X, clear burst count and clear outstanding count.
REQ-018 OWNX: o_s_cyc=i_mX_cyc, o_s_stb=i_mX_stb, o_s_data=i_mX_data, o_mX_stall=i_s_stall, o_mX_ack=i_s_ack; the other master stall=1, ack=0.
REQ-019 Accepted strobe = o_s_stb && !i_s_stall; each SHALL increment burst count (saturating at MAX_BURST) and outstanding count.
REQ-020 Each i_s_ack SHALL decrement outstanding; accept and ack in the same cycle leave outstanding unchanged; outstanding SHALL never underflow (ack at 0 ignored).
REQ-021 Outstanding width SHALL be clog2(MAX_BURST)+1 bits.
REQ-022 OWNX with burst count == MAX_BURST and the other cyc=1 SHALL go to DRAINX.
REQ-023 DRAINX: o_s_cyc=1, o_s_stb=0, o_mX_stall=1, o_mX_ack=i_s_ack; go to OWN(other) when outstanding==0 (including the decrement of the current cycle).
REQ-024 OWNX with i_mX_cyc=0 SHALL go to IDLE next cycle, abandon outstanding, and forward no later acks to any master.
REQ-025 Burst count at MAX_BURST with the other cyc=0 SHALL keep the grant; the count stays saturated.
REQ-026 o_grant SHALL be 01 in OWN0/DRAIN0, 10 in OWN1/DRAIN1, 00 in IDLE.
REQ-027 Grant changes SHALL take effect only on a clock edge; no master sees ack=1 unless it owns or drains.

Reset
REQ-028 i_reset_n=0 at a clock edge SHALL force IDLE, last=1, counters=0; outputs then o_s_cyc=0, o_s_stb=0, o_s_data=0, acks=0, stalls=1, o_grant=00.
REQ-029 Reset mid-transfer SHALL drop any outstanding ack tracking; the first grant after reset follows REQ-016.

Verification
REQ-030 m0 cyc+stb data 0x41 alone, i_s_stall=0, ack one cycle later -> grant 01 after 1 cycle, o_s_data=0x41, o_m0_ack pulses once, o_m1_ack=0.
REQ-031 m0 and m1 raise cyc in the same cycle after reset -> o_grant=01; after m0 drops cyc -> IDLE, then o_grant=10.
REQ-032 m0 streams 20 bytes, m1 cyc=1, MAX_BURST=16 -> exactly 16 accepted, DRAIN0 until 16 acks, then o_grant=10, m0 stalled.
REQ-033 i_s_stall=1 for 3 cycles during OWN1 -> o_m1_stall=1 for those 3 cycles, burst and outstanding counts unchanged, no data loss.
REQ-034 Reset asserted in DRAIN0 with outstanding=2 -> next cycle o_grant=00, acks arriving afterwards reach neither master.
REQ-035 Accept and ack in the same cycle for 10 consecutive cycles -> outstanding stays 1, burst count increments each cycle.
